// File: rtl/mac_ctrl_if.sv
// Job request and SRAM/array control bundle between the core FSM side and mac_ctrl.
interface mac_ctrl_if #(
  parameter int addr_w = 11,
  parameter int len_w  = 11
);
  logic              start;
  logic [len_w-1:0]  len;
  logic [addr_w-1:0] w_base;
  logic [addr_w-1:0] x_base;
  logic              unsign_cfg;
  logic              ofifo_full;
  logic              rd_en;
  logic              rd_sel;
  logic [addr_w-1:0] rd_addr;
  logic [1:0]        inst;
  logic              unsign;
  logic              busy;
  logic              done;

  modport master (
    output start, len, w_base, x_base, unsign_cfg, ofifo_full,
    input  rd_en, rd_sel, rd_addr, inst, unsign, busy, done
  );

  modport slave (
    input  start, len, w_base, x_base, unsign_cfg, ofifo_full,
    output rd_en, rd_sel, rd_addr, inst, unsign, busy, done
  );
endinterface

// File: rtl/mac_ctrl.sv
// Job sequencer for mac_array: weight load, activation execute, pipeline drain.
module mac_ctrl #(
  parameter int col    = 8,
  parameter int bw     = 4,
  parameter int pr     = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 11,
  parameter int drain  = 10
) (
  input  logic     clk,
  input  logic     reset,
  mac_ctrl_if.slave bus
);
  // One shared counter walks k (LOAD), j (EXEC) and the drain count, so it
  // must be wide enough for whichever of the three is largest.
  localparam int CW_A = (len_w > $clog2(col + 1)) ? len_w : $clog2(col + 1);
  localparam int CW   = (CW_A > $clog2(drain + 1)) ? CW_A : $clog2(drain + 1);

  // Parameter legality: drain must outlast the array skew, widths must be real.
  if (drain < col + 2) begin : g_bad_drain
    $error("mac_ctrl: drain must be >= col+2");
  end
  if (bw < 1 || pr < 1) begin : g_bad_geom
    $error("mac_ctrl: bw and pr must be positive");
  end

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [len_w-1:0]  len_r;
  logic [addr_w-1:0] w_base_r, x_base_r;
  logic              unsign_r;
  logic              capture;
  logic              rd_en, rd_sel;
  logic [addr_w-1:0] rd_addr;
  logic [1:0]        inst;

  // Next-state, counter and read-port decode; addresses wrap silently at addr_w.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    rd_en     = 1'b0;
    rd_sel    = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        rd_en   = 1'b1;
        rd_addr = w_base_r + addr_w'(cnt);
        if (cnt == CW'(col - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (len_r == '0) ? DRAIN : EXEC;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      EXEC: begin
        // Back-pressure holds j and suppresses the issue for this cycle.
        if (!bus.ofifo_full) begin
          rd_en   = 1'b1;
          rd_sel  = 1'b1;
          rd_addr = x_base_r + addr_w'(cnt);
          if (cnt + CW'(1) == CW'(len_r)) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == CW'(drain - 1)) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Job fields latch only on an accepted start, so a start while busy cannot disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r    <= '0;
      w_base_r <= '0;
      x_base_r <= '0;
      unsign_r <= 1'b0;
    end else if (capture) begin
      len_r    <= bus.len;
      w_base_r <= bus.w_base;
      x_base_r <= bus.x_base;
      unsign_r <= bus.unsign_cfg;
    end
  end

  // inst trails the read by one cycle to line up with SRAM data at the array.
  always_ff @(posedge clk) begin
    if (reset) inst <= 2'b00;
    else       inst <= {rd_en & rd_sel, rd_en & ~rd_sel};
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_sel  = rd_sel;
  assign bus.rd_addr = rd_addr;
  assign bus.inst    = inst;
  assign bus.unsign  = (state != IDLE) & unsign_r;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencer for the `mac_array` datapath. It accepts one job (start, vector count, base addresses, sign mode) and walks the array through weight load, activation execute and pipeline drain. During each phase it drives the shared SRAM read port and the array's `inst`/`unsign` inputs. It throttles execution on output-FIFO back-pressure and signals completion with a one-cycle `done` pulse. It sits between the top-level core FSM and `mac_array` plus its input SRAMs.

## Interface

**Parameters**
- `col`, 8: number of array columns; also the number of weight vectors loaded.
- `bw`, 4: operand bit width (passed through for consistency with `mac_array`).
- `pr`, 8: lanes per column.
- `addr_w`, 11: SRAM address width.
- `len_w`, 11: width of the execute-vector count.
- `drain`, 10: cycles spent in DRAIN after the last execute issue; must be ≥ col+2.

**Ports**
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  len_w  number of activation vectors to execute; captured on start.
- `w_base`  in  addr_w  weight SRAM base address; captured on start.
- `x_base`  in  addr_w  activation SRAM base address; captured on start.
- `unsign_cfg`  in  1  sign mode for the job; captured on start.
- `ofifo_full`  in  1  output FIFO cannot accept data; stalls execute issue.
- `rd_en`  out  1  SRAM read strobe.
- `rd_sel`  out  1  read source: 0 = weight SRAM, 1 = activation SRAM.
- `rd_addr`  out  addr_w  SRAM read address.
- `inst`  out  2  to `mac_array`: [1] execute, [0] load.
- `unsign`  out  1  to `mac_array`; holds the captured `unsign_cfg`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation

- **States:** IDLE, LOAD, EXEC, DRAIN, DONE.
- **IDLE:** all outputs 0. If `start` is high, capture `len`, `w_base`, `x_base` and `unsign_cfg`, clear counters, and go to LOAD.
- **LOAD:** `rd_en`=1, `rd_sel`=0, `rd_addr`=w_base+k for k=0..col-1, one read per cycle, never stalled. After k=col-1, go to EXEC, or to DRAIN if captured `len`=0.
- **EXEC:** each cycle with `ofifo_full`=0 issues `rd_en`=1, `rd_sel`=1, `rd_addr`=x_base+j and increments j. Cycles with `ofifo_full`=1 issue nothing (`rd_en`=0) and hold j. After j=len-1 issues, go to DRAIN.
- **DRAIN:** no reads; count `drain` cycles, then go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **`inst` generation:** `inst` is a register loaded each cycle from the read issued the previous cycle (SRAM latency 1), so `inst` aligns with SRAM data at `mac_array.in`.
  - Previous cycle issued a weight read: `inst`=01.
  - Previous cycle issued an activation read: `inst`=10.
  - No read issued: `inst`=00.
  - `inst`=11 never occurs.
- **`unsign`:** equals the captured `unsign_cfg` from the cycle after start until leaving DONE; 0 in IDLE.
- **Address arithmetic:** `rd_addr` is base + counter, truncated to addr_w bits; wrap past 2^addr_w-1 to 0 is legal and silent.
- **`start` while busy:** ignored; it does not queue and does not alter the captured fields.
- **`ofifo_full`:** ignored outside EXEC. Asserted on the cycle the last execute would issue, it delays that issue and the transition to DRAIN.
- **Reset:** `reset` at any time, including mid-LOAD/EXEC/DRAIN, forces IDLE on the next edge. All outputs and counters go to 0, including the `inst` register; no `done` pulse is produced.

## Timing

- **Start handshake:** `start` high in cycle 0 gives `busy`=1 from cycle 1.
- **Weight reads:** cycles 1..col.
- **Load instruction:** `inst`=01 on cycles 2..col+1.
- **Execute, no stalls:** activation reads on cycles col+1..col+len; `inst`=10 on cycles col+2..col+len+1.
- **DRAIN:** cycles col+len+1..col+len+drain.
- **DONE:** `done`=1 on cycle col+len+drain+1; `busy` falls in cycle col+len+drain+2.
- **Stalls:** each stalled EXEC cycle shifts all later events by one cycle.
- **Zero length:** with `len`=0, DRAIN occupies cycles col+1..col+drain.
- **Back-to-back jobs:** the earliest next `start` is accepted in the first IDLE cycle after DONE.

## Test plan

1. **Nominal job:** reset, then start with len=4, w_base=0x10, x_base=0x40, col=8, drain=10.
   - `rd_addr` 0x10..0x17 on cycles 1..8 with `rd_sel`=0.
   - `rd_addr` 0x40..0x43 on cycles 9..12 with `rd_sel`=1.
   - `inst`=01 on cycles 2..9 and 10 on cycles 10..13.
   - `done` on cycle 23.
2. **Back-pressure:** same job, `ofifo_full`=1 on cycles 10 and 11.
   - No read on those cycles; addresses 0x41..0x43 on cycles 12..14.
   - `inst`=00 on cycles 11..12.
   - `done` on cycle 25.
3. **Zero length:** len=0.
   - Only 8 weight reads; `inst` never equals 10.
   - `done` on cycle 19.
4. **Busy-start and sign capture:** start re-asserted on cycles 5..15 with changed len and `unsign_cfg`.
   - Ignored; the first job completes unchanged and `unsign` stays at its captured value.
5. **Reset mid-EXEC:** reset asserted on cycle 10.
   - Cycle 11: all outputs 0, `busy`=0, no `done`.
   - A new start on cycle 12 runs a nominal job correctly.
6. **Address wrap:** addr_w=11, x_base=0x7FE, len=4.
   - Activation addresses 0x7FE, 0x7FF, 0x000, 0x001.
